add_rca_pipe: RTL and testbench
===============================

ADD_RCA_PIPE -- requirements
Module: add_rca_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (>=2).
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES (elaboration error otherwise).
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 X  input  WIDTH  operand A.
REQ-008 Y  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = X+Y+ci, 1 = X-Y.
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 co  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The datapath SHALL be a ripple-carry adder split into STAGES slices of WIDTH/STAGES bits, with carry registered between slices.
REQ-017 Slice k SHALL add operand bits [k*W/S +: W/S] using the incoming registered carry; slice 0 uses the effective carry-in.
REQ-018 In sub mode, Y SHALL be bitwise inverted and the effective carry-in SHALL be 1, with ci ignored; in add mode, the effective carry-in is ci.
REQ-019 Not-yet-consumed operand bits SHALL be skew-delayed, and completed low sum bits deskew-delayed, so all bits of one beat emerge together.
REQ-020 A beat is accepted when in_valid && in_ready; its result SHALL appear on out_valid/sum/co/ovf exactly STAGES cycles after acceptance when no stall occurs.
REQ-021 Pipeline advance enable adv = out_ready || !out_valid; all stage registers, including valid bits, SHALL update only when adv=1.
REQ-022 in_ready SHALL equal adv (combinational from out_ready and out_valid).
REQ-023 While out_valid=1 and out_ready=0, sum/co/ovf/out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-024 The sustained throughput SHALL be one beat per cycle with out_ready held at 1; bubbles (in_valid=0) propagate as out_valid=0.
REQ-025 co SHALL be the carry out of bit WIDTH-1; ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 Each beat's sub value SHALL travel with that beat; mode changes between consecutive beats SHALL take effect per beat.
REQ-027 When STAGES=1, the block SHALL degenerate to a single registered output stage with latency 1.

Reset
REQ-028 With rst=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0 on the following cycle; sum, co and ovf SHALL reset to 0.
REQ-029 Reset during in-flight beats SHALL discard them; no pre-reset beat SHALL emerge afterward.
REQ-030 in_ready SHALL be 1 in the first cycle after reset, since out_valid=0.

Structure
REQ-031 The datapath SHALL instantiate the existing full_adder cell (ports X, Y, ci, sum, co) once per bit; no separate sub-module beyond it.
REQ-032 No shared package is needed; slice width WIDTH/STAGES SHALL be a local constant.

Verification (WIDTH=16, STAGES=4)
REQ-033 Add X=FFFF, Y=0001, ci=0 -> 4 cycles later sum=0000, co=1, ovf=0.
REQ-034 Add X=7FFF, Y=0001, ci=0 -> sum=8000, co=0, ovf=1; then X=1234, Y=4321, ci=1 -> sum=5556, co=0, ovf=0.
REQ-035 Sub X=0005, Y=0007, with ci=1 applied and required to be ignored -> sum=FFFE, co=0, ovf=0; sub X=8000, Y=0001 -> sum=7FFF, co=1, ovf=1.
REQ-036 Present 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles beginning 4 cycles after the first beat, in order, against a reference model.
REQ-037 Deassert out_ready for 3 cycles while the pipe is full -> outputs held, in_ready=0, and after release all beats emerge once, in order.
REQ-038 Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 afterward until the next accepted beat completes 4 cycles after its acceptance.

Source files
------------

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the building block of the ripple-carry datapath.
module full_adder (
  input  logic X,
  input  logic Y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = X ^ Y ^ ci;
  assign co  = (X & Y) | (ci & (X ^ Y));

endmodule

// File: rtl/add_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// Each stage adds one slice of WIDTH/STAGES bits and registers the carry into the next slice.
module add_rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  generate
    if ((WIDTH % STAGES) != 0 || WIDTH < 2 || STAGES < 1) begin : g_badParam
      $error("add_rca_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end
  endgenerate

  logic             w_adv;
  logic [WIDTH-1:0] w_aIn   [STAGES];
  logic [WIDTH-1:0] w_bIn   [STAGES];
  logic [WIDTH-1:0] w_sumIn [STAGES];
  logic             w_vIn   [STAGES];
  logic [SW:0]      w_chain [STAGES];
  logic [SW-1:0]    w_slSum [STAGES];

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];
  logic             r_v   [STAGES];
  logic             r_ovf;

  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;

  // Operands travel down the pipe alongside the partial sum; the subtract
  // inversion happens at entry so each beat carries its own mode.
  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
        assign w_aIn[s]      = X;
        assign w_bIn[s]      = sub ? ~Y : Y;
        assign w_sumIn[s]    = '0;
        assign w_vIn[s]      = in_valid;
        assign w_chain[s][0] = sub | ci;
      end else begin : g_next
        assign w_aIn[s]      = r_a[s-1];
        assign w_bIn[s]      = r_b[s-1];
        assign w_sumIn[s]    = r_sum[s-1];
        assign w_vIn[s]      = r_v[s-1];
        assign w_chain[s][0] = r_c[s-1];
      end

      for (genvar j = 0; j < SW; j++) begin : g_bit
        full_adder u_fa (
          .X   (w_aIn[s][s*SW + j]),
          .Y   (w_bIn[s][s*SW + j]),
          .ci  (w_chain[s][j]),
          .sum (w_slSum[s][j]),
          .co  (w_chain[s][j+1])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s]   <= 1'b0;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
        r_c[s]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s]               <= w_vIn[s];
        r_a[s]               <= w_aIn[s];
        r_b[s]               <= w_bIn[s];
        r_sum[s]             <= w_sumIn[s];
        r_sum[s][s*SW +: SW] <= w_slSum[s];
        r_c[s]               <= w_chain[s][SW];
      end
      // Carry into the MSB is the second-to-last tap of the final slice's chain.
      r_ovf <= w_chain[STAGES-1][SW-1] ^ w_chain[STAGES-1][SW];
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign co        = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_add_rca_pipe.sv
// Directed self-checking bench for add_rca_pipe at WIDTH=16, STAGES=4.
module tb_add_rca_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  int checks;
  int fails;

  logic [15:0] vecX [8];
  logic [15:0] vecY [8];
  logic        vecC [8];
  logic        vecS [8];
  logic [15:0] expSum [8];
  logic        expCo  [8];
  logic        expOvf [8];

  add_rca_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {ovf, co, sum} from plain integer arithmetic and operand signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] r;
    logic        o;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    o  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {o, r[16], r[15:0]};
  endfunction

  // Presents one beat to an idle pipe and reports how many edges it took to emerge.
  task automatic issue_beat(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic s, output int lat, output logic [15:0] gs,
                            output logic gc, output logic go);
    X = x; Y = y; ci = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    gs = sum; gc = co; go = ovf;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin fails++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if ({co, ovf} !== 2'b00) begin fails++; $display("[TB] FAIL reset_co_ovf: got %b expected 00", {co, ovf}); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    int lat; logic [15:0] gs; logic gc, go;
    issue_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, gs, gc, go);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL add_wrap_latency: got %0d expected 4", lat); end
    checks++; if ({gs, gc, go} !== {16'h0000, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL add_wrap: got %h/%b/%b expected 0000/1/0", gs, gc, go); end
    idle(2);
    issue_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, gs, gc, go);
    checks++; if ({gs, gc, go} !== {16'h8000, 1'b0, 1'b1}) begin fails++; $display("[TB] FAIL add_ovf: got %h/%b/%b expected 8000/0/1", gs, gc, go); end
    idle(2);
    issue_beat(16'h1234, 16'h4321, 1'b1, 1'b0, lat, gs, gc, go);
    checks++; if ({gs, gc, go} !== {16'h5556, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL add_ci: got %h/%b/%b expected 5556/0/0", gs, gc, go); end
    idle(2);
  endtask

  task automatic test_sub();
    int lat; logic [15:0] gs; logic gc, go;
    issue_beat(16'h0005, 16'h0007, 1'b1, 1'b1, lat, gs, gc, go);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL sub_latency: got %0d expected 4", lat); end
    checks++; if ({gs, gc, go} !== {16'hFFFE, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL sub_neg_ci_ignored: got %h/%b/%b expected FFFE/0/0", gs, gc, go); end
    idle(2);
    issue_beat(16'h8000, 16'h0001, 1'b0, 1'b1, lat, gs, gc, go);
    checks++; if ({gs, gc, go} !== {16'h7FFF, 1'b1, 1'b1}) begin fails++; $display("[TB] FAIL sub_ovf: got %h/%b/%b expected 7FFF/1/1", gs, gc, go); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int inIdx, outIdx;
    logic acc, cons;
    inIdx = 0; outIdx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && outIdx < 8; cyc++) begin
      in_valid = (inIdx < 8);
      if (inIdx < 8) begin X = vecX[inIdx]; Y = vecY[inIdx]; ci = vecC[inIdx]; sub = vecS[inIdx]; end
      #1;
      if (out_valid) begin
        checks++; if (cyc != outIdx + 4) begin fails++; $display("[TB] FAIL b2b_timing beat %0d: got cycle %0d expected %0d", outIdx, cyc, outIdx + 4); end
        checks++; if ({sum, co, ovf} !== {expSum[outIdx], expCo[outIdx], expOvf[outIdx]}) begin
          fails++; $display("[TB] FAIL b2b_data beat %0d: got %h/%b/%b expected %h/%b/%b", outIdx, sum, co, ovf, expSum[outIdx], expCo[outIdx], expOvf[outIdx]);
        end
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) inIdx++;
      if (cons) outIdx++;
    end
    in_valid = 1'b0;
    checks++; if (outIdx != 8) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 8", outIdx); end
    idle(2);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_no_extra: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    int inIdx, outIdx;
    logic acc, cons;
    inIdx = 0; outIdx = 0;
    for (int cyc = 0; cyc < 40 && outIdx < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid = (inIdx < 8);
      if (inIdx < 8) begin X = vecX[inIdx]; Y = vecY[inIdx]; ci = vecC[inIdx]; sub = vecS[inIdx]; end
      #1;
      if (!out_ready) begin
        checks++; if ({out_valid, in_ready} !== 2'b10) begin fails++; $display("[TB] FAIL stall_hold cycle %0d: got valid/ready %b expected 10", cyc, {out_valid, in_ready}); end
      end
      if (out_valid) begin
        checks++; if ({sum, co, ovf} !== {expSum[outIdx], expCo[outIdx], expOvf[outIdx]}) begin
          fails++; $display("[TB] FAIL stall_data beat %0d: got %h/%b/%b expected %h/%b/%b", outIdx, sum, co, ovf, expSum[outIdx], expCo[outIdx], expOvf[outIdx]);
        end
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) inIdx++;
      if (cons) outIdx++;
    end
    in_valid = 1'b0;
    checks++; if (outIdx != 8) begin fails++; $display("[TB] FAIL stall_count: got %0d expected 8", outIdx); end
    idle(2);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    int lat; logic [15:0] gs; logic gc, go;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      X = vecX[k]; Y = vecY[k]; ci = vecC[k]; sub = vecS[k]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({out_valid, sum} !== 17'h0) begin fails++; $display("[TB] FAIL rstflight_clear: got %b/%h expected 0/0000", out_valid, sum); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstflight_discard cycle %0d: got %b expected 0", k, out_valid); end
    end
    issue_beat(16'h00F0, 16'h000F, 1'b0, 1'b0, lat, gs, gc, go);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL rstflight_latency: got %0d expected 4", lat); end
    checks++; if ({gs, gc, go} !== {16'h00FF, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL rstflight_data: got %h/%b/%b expected 00FF/0/0", gs, gc, go); end
    idle(2);
  endtask

  initial begin
    logic [17:0] m;
    checks = 0;
    fails  = 0;
    vecX = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF, 16'h00FF, 16'hABCD, 16'h0000};
    vecY = '{16'h0002, 16'h0001, 16'h8000, 16'h4321, 16'h7FFF, 16'h0F01, 16'h1234, 16'h0001};
    vecC = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecS = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      m = model(vecX[k], vecY[k], vecC[k], vecS[k]);
      expSum[k] = m[15:0];
      expCo[k]  = m[16];
      expOvf[k] = m[17];
    end

    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_inflight();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
